// File: rtl/dmem_if.sv
// CPU-side data-memory bus: request strobes, address/store data in; load data and stall back.
interface dmem_if;
  logic        MemWrite;
  logic        MemRead;
  logic        ByteAccess;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;

  modport master (
    output MemWrite, MemRead, ByteAccess, Addr, WriteData,
    input  ReadData, Stall
  );

  modport slave (
    input  MemWrite, MemRead, ByteAccess, Addr, WriteData,
    output ReadData, Stall
  );
endinterface

// File: rtl/dmem_controller.sv
// Data-memory stage: synchronous-read word RAM with byte lanes, MMIO (output reg, synced input,
// cycle counter) and a two-state load FSM that stalls the CPU for the first load cycle.
module dmem_controller #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] IO_BASE     = 32'h0001_0000
) (
  input  logic       clk,
  input  logic       reset,
  dmem_if.slave      bus,
  input  logic [7:0] IoIn,
  output logic [7:0] IoOut,
  output logic       AlignErr,
  output logic       DecodeErr
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] RAM_BYTES = 33'(4 * DEPTH_WORDS);
  localparam logic [29:0] IO_W      = IO_BASE[31:2];

  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] READ_WAIT = 1'b1;

  function automatic logic [31:0] lane_select(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic        byte_sel);
    if (byte_sel) return {24'b0, word[{lane, 3'b000} +: 8]};
    return word;
  endfunction

  logic [0:0]  state;
  logic        accept_wr, accept_rd;
  logic        is_ram, is_out, is_in, is_cnt, unmapped, misalign;
  logic [AW-1:0] idx;
  logic [3:0]  lane_we;
  logic [31:0] mem [DEPTH_WORDS];
  logic [7:0]  sync1, sync2;
  logic [31:0] count, count_next;
  logic [31:0] io_word;
  logic [31:0] ram_p0, io_p0;
  logic [1:0]  lane_p0;
  logic        byte_p0, src_ram_p0;
  logic [31:0] load_word, read_hold;

  // Accepted requests are evaluated only in IDLE; READ_WAIT ignores the bus.
  assign accept_wr = (state == IDLE) && bus.MemWrite;
  assign accept_rd = (state == IDLE) && bus.MemRead && !bus.MemWrite;
  assign bus.Stall = accept_rd;

  assign idx      = bus.Addr[AW+1:2];
  assign is_ram   = {1'b0, bus.Addr} < RAM_BYTES;
  assign is_out   = bus.Addr[31:2] == IO_W;
  assign is_in    = bus.Addr[31:2] == IO_W + 30'd1;
  assign is_cnt   = bus.Addr[31:2] == IO_W + 30'd2;
  assign unmapped = !(is_ram || is_out || is_in || is_cnt);
  assign misalign = !bus.ByteAccess && (bus.Addr[1:0] != 2'b00);

  always_comb begin
    lane_we = 4'b0000;
    if (accept_wr && is_ram)
      lane_we = bus.ByteAccess ? (4'b0001 << bus.Addr[1:0]) : 4'b1111;
  end

  always_comb begin
    count_next = count + 32'd1;
    if (accept_wr && is_cnt) count_next = 32'd0;
  end

  always_comb begin
    io_word = 32'd0;
    if (is_out)      io_word = {24'b0, IoOut};
    else if (is_in)  io_word = {24'b0, sync2};
    // A counter load returns the value the counter takes at the capturing edge.
    else if (is_cnt) io_word = count_next;
  end

  // p0: RAM array and load capture (data only, no reset)
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (lane_we[i])
        mem[idx][8*i +: 8] <= bus.ByteAccess ? bus.WriteData[7:0] : bus.WriteData[8*i +: 8];
    end
    if (accept_rd) begin
      ram_p0     <= mem[idx];
      io_p0      <= io_word;
      lane_p0    <= bus.Addr[1:0];
      byte_p0    <= bus.ByteAccess;
      src_ram_p0 <= is_ram;
    end
  end

  assign load_word    = lane_select(src_ram_p0 ? ram_p0 : io_p0, lane_p0, byte_p0);
  assign bus.ReadData = (state == READ_WAIT) ? load_word : read_hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      read_hold <= 32'd0;
      IoOut     <= 8'd0;
      count     <= 32'd0;
      sync1     <= 8'd0;
      sync2     <= 8'd0;
      AlignErr  <= 1'b0;
      DecodeErr <= 1'b0;
    end else begin
      sync1 <= IoIn;
      sync2 <= sync1;
      count <= count_next;
      if (state == READ_WAIT) begin
        read_hold <= load_word;
        state     <= IDLE;
      end else if (accept_rd) begin
        state <= READ_WAIT;
      end
      if (accept_wr && is_out) IoOut <= bus.WriteData[7:0];
      if (accept_wr || accept_rd) begin
        if (misalign) AlignErr  <= 1'b1;
        if (unmapped) DecodeErr <= 1'b1;
      end
    end
  end

endmodule
